// File: rtl/serial_pkg.sv
// Shared definitions for the serial link transmitter and receiver:
// the frame state encoding and the fixed line levels.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts clock cycles inside one bit and flags the last one.
// Shared unchanged between the transmitter and the receiver.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bitDone
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Wraps to zero at each bit boundary so the next bit starts fresh.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign bitDone = enable && !clear && (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: start bit, data LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] inData,
    input  logic                  inValid,
    output logic                  outReady,
    output logic                  outSerial,
    output logic                  outBusy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic [IDX_W-1:0]        bit_index;
    logic                    bit_done;
`ifdef SERIAL_TX_PARITY_EN
    logic                    parity_bit;
`endif

    assign shift_next = shift_reg >> 1;

    // The timer is held at zero while idle so a new frame always starts a full bit period.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (state != IDLE),
        .bitDone(bit_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_index <= '0;
            outSerial <= LINE_IDLE;
            outReady  <= 1'b1;
            outBusy   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    outSerial <= LINE_IDLE;
                    outReady  <= 1'b1;
                    outBusy   <= 1'b0;
                    if (inValid && outReady) begin
                        shift_reg <= inData;
                        bit_index <= '0;
                        state     <= START;
                        outSerial <= START_BIT;
                        outReady  <= 1'b0;
                        outBusy   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                        parity_bit <= ^inData;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state     <= DATA;
                        bit_index <= '0;
                        outSerial <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_index == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                            state     <= PARITY;
                            outSerial <= parity_bit;
`else
                            state     <= STOP;
                            outSerial <= STOP_BIT;
`endif
                        end else begin
                            shift_reg <= shift_next;
                            bit_index <= bit_index + 1'b1;
                            outSerial <= shift_next[0];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state     <= STOP;
                        outSerial <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        state     <= IDLE;
                        outSerial <= LINE_IDLE;
                        outReady  <= 1'b1;
                        outBusy   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    outSerial <= LINE_IDLE;
                    outReady  <= 1'b1;
                    outBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: expected line bits are queued at each handshake
// and compared cycle by cycle; also exercises a DATA_WIDTH=1, CLKS_PER_BIT=1 instance.
module tb_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME = (DW + 3) * CPB;
`else
    localparam int FRAME = (DW + 2) * CPB;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] inData = '0;
    logic          inValid = 1'b0;
    logic          outReady, outSerial, outBusy;

    logic [0:0]    inData1 = '0;
    logic          inValid1 = 1'b0;
    logic          outReady1, outSerial1, outBusy1;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic exp_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) u_dut (
        .clock(clock), .reset(reset), .inData(inData), .inValid(inValid),
        .outReady(outReady), .outSerial(outSerial), .outBusy(outBusy)
    );

    serial_tx #(.DATA_WIDTH(1), .CLKS_PER_BIT(1)) u_dut1 (
        .clock(clock), .reset(reset), .inData(inData1), .inValid(inValid1),
        .outReady(outReady1), .outSerial(outSerial1), .outBusy(outBusy1)
    );

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_serial"}, outSerial, 1'b1);
        checkOutput({tag, "_ready"}, outReady, 1'b1);
        checkOutput({tag, "_busy"}, outBusy, 1'b0);
    endtask

    task automatic pushFrame(input logic [DW-1:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Waits (bounded) for outReady, then performs one handshake; returns #1 after the edge.
    task automatic applyStimulus(input logic [DW-1:0] d);
        int budget = 200;
        while (outReady !== 1'b1 && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        checkOutput("ready_wait", outReady, 1'b1);
        inData  = d;
        inValid = 1'b1;
        @(posedge clock); #1;
        inValid = 1'b0;
        pushFrame(d);
    endtask

    // Compares every cycle of the queued frame, then the idle cycle that follows.
    task automatic checkFrame(input bit disturb);
        logic b;
        int   k = 0;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            for (int c = 0; c < CPB; c++) begin
                checkOutput("line", outSerial, b);
                checkOutput("busy", outBusy, 1'b1);
                checkOutput("ready", outReady, 1'b0);
                if (disturb) begin
                    inData  = DW'($urandom);
                    inValid = k[0];
                end
                k++;
                @(posedge clock); #1;
            end
        end
        if (disturb) inValid = 1'b0;
        checkIdle("frame_end");
    endtask

    initial begin
        int t1, t2;

        // Reset held for three cycles, outputs checked while in reset.
        repeat (3) @(posedge clock);
        #1;
        checkIdle("in_reset");
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            checkIdle("idle");
        end

        // Single frame 0xA5.
        $display("[TB] single frame 0xA5");
        applyStimulus(8'hA5);
        checkFrame(1'b0);

        // Back-to-back 0x00 then 0xFF with inValid held high.
        $display("[TB] back-to-back frames");
        inData  = 8'h00;
        inValid = 1'b1;
        @(posedge clock); #1;
        t1 = cyc;
        pushFrame(8'h00);
        inData = 8'hFF;
        checkFrame(1'b0);
        @(posedge clock); #1;
        t2 = cyc;
        inValid = 1'b0;
        checkOutput("b2b_start", outSerial, 1'b0);
        checkValue("b2b_spacing", t2 - t1, FRAME + 1);
        pushFrame(8'hFF);
        checkFrame(1'b0);

        // Input activity during a frame must be ignored.
        $display("[TB] ignored input during 0x3C");
        applyStimulus(8'h3C);
        checkFrame(1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            checkIdle("no_extra_frame");
        end

        // Asynchronous reset in data bit 3 of 0x55.
        $display("[TB] reset mid-frame");
        applyStimulus(8'h55);
        repeat (18) @(posedge clock);
        #1;
        checkOutput("pre_reset_line", outSerial, 1'b0);
        checkOutput("pre_reset_busy", outBusy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkIdle("async_reset");
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        checkIdle("post_reset");
        applyStimulus(8'h81);
        checkFrame(1'b0);

`ifdef SERIAL_TX_PARITY_EN
        $display("[TB] parity frames");
        applyStimulus(8'h07);
        checkValue("parity_07", int'(exp_q[DW + 1]), 1);
        checkFrame(1'b0);
        applyStimulus(8'h03);
        checkValue("parity_03", int'(exp_q[DW + 1]), 0);
        checkFrame(1'b0);
`endif

        // DATA_WIDTH=1, CLKS_PER_BIT=1 instance: one cycle per bit.
        $display("[TB] single-bit instance");
        for (int v = 0; v < 2; v++) begin
            logic bitv;
            bitv = (v == 0);
            checkOutput("w1_ready", outReady1, 1'b1);
            inData1  = bitv;
            inValid1 = 1'b1;
            @(posedge clock); #1;
            inValid1 = 1'b0;
            checkOutput("w1_start", outSerial1, 1'b0);
            checkOutput("w1_busy", outBusy1, 1'b1);
            @(posedge clock); #1;
            checkOutput("w1_data", outSerial1, bitv);
`ifdef SERIAL_TX_PARITY_EN
            @(posedge clock); #1;
            checkOutput("w1_parity", outSerial1, bitv);
`endif
            @(posedge clock); #1;
            checkOutput("w1_stop", outSerial1, 1'b1);
            checkOutput("w1_stop_busy", outBusy1, 1'b1);
            @(posedge clock); #1;
            checkOutput("w1_idle_busy", outBusy1, 1'b0);
            checkOutput("w1_idle_ready", outReady1, 1'b1);
            checkOutput("w1_idle_line", outSerial1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-in, serial-out transmitter, the send side of the team's serial link. It is the counterpart of the shift-register receiver built from the D/T flip-flop library.
- Accepts one DATA_WIDTH word through a valid/ready handshake.
- Emits the word as a frame: start bit 0, data bits LSB first, stop bit 1. Each bit lasts CLKS_PER_BIT clock cycles.
- The line idles high.

Parameters:
DATA_WIDTH, 8, number of payload bits per frame (legal range 1..16)
CLKS_PER_BIT, 4, clock cycles each bit is held on the line (legal range >= 1)

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
inData  input  DATA_WIDTH  word to transmit; sampled only on handshake
inValid  input  1  producer has a word on inData
outReady  output  1  transmitter can accept a word this cycle
outSerial  output  1  serial line, idle high
outBusy  output  1  frame in progress (from the start bit through the last stop-bit cycle)

Behaviour:
- Reset (reset=0, asynchronous) gives outSerial=1, outReady=1, outBusy=0, state IDLE, bit timer=0, bit index=0, shift register=0.
- Reset takes effect immediately when asserted. If it arrives mid-frame, the line returns high at once and the word is discarded; no partial stop bit is sent.
- Release: the first rising edge with reset=1 may already accept a word.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Handshake: a transfer occurs on a rising edge where inValid=1 and outReady=1.
  - inData is latched into the shift register on that edge.
  - On the same edge outReady goes 0, outBusy goes 1 and outSerial goes 0 (start bit).
  - inValid while outReady=0 is ignored; the producer holds it.
- State machine:
  - IDLE: outSerial=1, outReady=1. On transfer go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive shift register bit 0 for CLKS_PER_BIT cycles, then shift right. After DATA_WIDTH bits go to PARITY if that feature is enabled, otherwise to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. On the final cycle's edge go to IDLE with outReady=1 and outBusy=0.
- Bit timer: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT+1). It wraps to 0 at each bit boundary. CLKS_PER_BIT=1 gives one cycle per bit with no stall.
- Latency: the start bit appears on the edge after the handshake edge.
- Frame length is F = (DATA_WIDTH+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT if parity is enabled.
- Back-to-back: with inValid held high, the next handshake happens on the edge where outReady has just returned to 1. Minimum spacing between start bits is F+1 cycles, so the line sees one idle-high cycle between frames.
- Boundary cases:
  - DATA_WIDTH=1 sends a single data bit.
  - inData changing mid-frame has no effect.
  - The bit index never exceeds DATA_WIDTH-1.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the latched word) for CLKS_PER_BIT cycles, and the frame grows by CLKS_PER_BIT.
- Undefined: there is no PARITY state, no parity register and no parity logic; DATA goes directly to STOP.

Decomposition:
- Package serial_pkg holds:
  - the state encoding typedef (IDLE, START, DATA, PARITY, STOP);
  - LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
  - The matching receiver shares this package.
- One natural sub-module, bit_timer:
  - parameter CLKS_PER_BIT; inputs clock, reset, clear, enable; output bitDone;
  - bitDone pulses for one cycle on the last cycle of each bit period;
  - reused unchanged by the receiver.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, no inValid for 20 cycles -> outSerial=1, outReady=1, outBusy=0 throughout.
- Single frame: DATA_WIDTH=8, CLKS_PER_BIT=4, send 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; outBusy high for exactly 40 cycles; outReady returns 1 on cycle 41.
- Back-to-back: inValid held high with 0x00 then 0xFF -> second start bit begins exactly 41 cycles after the first; exactly one idle-high cycle in between.
- Ignored input: toggle inData and pulse inValid during a frame of 0x3C -> transmitted bits still 0,0,1,1,1,1,0,0; no extra frame is sent.
- Reset mid-frame: assert reset during data bit 3 of 0x55 -> outSerial=1 in the same cycle, asynchronously; after release outReady=1 and the next word 0x81 is sent correctly.
- Parity (SERIAL_TX_PARITY_EN defined): send 0x07 -> parity bit 1 after the data bits; frame is 44 cycles. Send 0x03 -> parity bit 0.
